// File: rtl/barcode_id_rcv_if.sv
// ----------------------------------------------------------------------------
// barcode_id_rcv_if
//   Bundles the barcode line and the station-ID handshake between the
//   barcode receiver and the command/control side.
//
//   Signals:
//     BC         : raw barcode line, idle high, asynchronous to clk
//     clr_ID_vld : consumer acknowledge, clears ID_vld
//     ID         : last accepted station ID, stable while ID_vld=1
//     ID_vld     : new valid ID available, held until cleared
//
//   Modports:
//     master : line / consumer side (drives BC and clr_ID_vld)
//     slave  : receiver side (barcode_id_rcv)
// ----------------------------------------------------------------------------
interface barcode_id_rcv_if;
  logic       BC;
  logic       clr_ID_vld;
  logic [7:0] ID;
  logic       ID_vld;

  modport master (output BC, output clr_ID_vld, input ID, input ID_vld);
  modport slave  (input BC, input clr_ID_vld, output ID, output ID_vld);
endinterface

// File: rtl/barcode_id_rcv.sv
// ----------------------------------------------------------------------------
// barcode_id_rcv
//   Decodes the self-clocked station-ID barcode stripe into an 8-bit ID.
//   A frame is one start bit followed by 8 data bits, MSB first. The low
//   time of the start bit sets the period T; each data bit is sampled T+1
//   cycles after its falling edge (long low = 0, short low = 1). Frames
//   with ID[7:6] != 2'b00 are discarded.
//
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     bus   : barcode_id_rcv_if.slave (BC, clr_ID_vld in; ID, ID_vld out)
//
//   Parameters:
//     PERIOD_W    : width of the period/timeout counter (all-ones = timeout)
//     SYNC_STAGES : metastability flops on BC (minimum 2)
//
//   Optional build macro:
//     BC_GLITCH_FILT_EN : 3-sample consistency filter on the synced line;
//                         rejects 1-2 cycle pulses, adds 2 cycles latency.
// ----------------------------------------------------------------------------
module barcode_id_rcv #(
  parameter int PERIOD_W    = 22,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  barcode_id_rcv_if.slave        bus
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, START, WAIT_FALL, BIT_DLY, DONE} state_t;

  // Synchronizer, preset to the idle-high line level
  logic [SYNC_STAGES-1:0] sync;
  logic                   bc_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '1;
    else        sync <= {sync[SYNC_STAGES-2:0], bus.BC};
  end

  assign bc_s = sync[SYNC_STAGES-1];

  // Line level seen by the decoder (bc_cur) and its value one cycle earlier
  logic bc_cur;
  logic bc_prev;

`ifdef BC_GLITCH_FILT_EN
  // The filtered level follows the synced line only once three consecutive
  // samples agree. Using the combinational result as the current level and
  // the registered one as history keeps the added latency to 2 cycles.
  logic [1:0] flt_hist;

  always_comb begin
    bc_cur = bc_prev;
    if (bc_s == flt_hist[0] && bc_s == flt_hist[1]) bc_cur = bc_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_hist <= 2'b11;
      bc_prev  <= 1'b1;
    end else begin
      flt_hist <= {flt_hist[0], bc_s};
      bc_prev  <= bc_cur;
    end
  end
`else
  assign bc_cur = bc_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bc_prev <= 1'b1;
    else        bc_prev <= bc_cur;
  end
`endif

  logic fall, rise;
  assign fall =  bc_prev & ~bc_cur;
  assign rise = ~bc_prev &  bc_cur;

  // Decoder state
  state_t              state, state_n;
  logic [PERIOD_W-1:0] cnt, cnt_n, cnt_inc;
  logic [PERIOD_W-1:0] period, period_n;
  logic [7:0]          shift, shift_n;
  logic [2:0]          bit_cnt, bit_cnt_n;
  logic [7:0]          id_q;
  logic                id_vld_q;
  logic                load_id;

  // Counter saturates instead of wrapping so all-ones stays a timeout
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + PERIOD_W'(1);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt_inc;
    period_n  = period;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    load_id   = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (fall) begin
          state_n   = START;
          bit_cnt_n = 3'd0;
        end
      end

      START: begin
        if (rise) begin
          cnt_n = '0;
          // A zero-length start low is a glitch, not a frame
          if (cnt == '0) begin
            state_n = IDLE;
          end else begin
            period_n = cnt;
            state_n  = WAIT_FALL;
          end
        end else if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end

      WAIT_FALL: begin
        if (fall) begin
          cnt_n   = '0;
          state_n = BIT_DLY;
        end else if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end

      BIT_DLY: begin
        if (cnt == period) begin
          shift_n   = {shift[6:0], bc_cur};
          bit_cnt_n = bit_cnt + 3'd1;
          cnt_n     = '0;
          state_n   = (bit_cnt == 3'd7) ? DONE : WAIT_FALL;
        end
      end

      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
        if (shift[7:6] == 2'b00) load_id = 1'b1;
      end

      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= '0;
      shift   <= '0;
      bit_cnt <= 3'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      period  <= period_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
    end
  end

  // Output handshake: set wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q     <= 8'h00;
      id_vld_q <= 1'b0;
    end else begin
      if (load_id) id_q <= shift;
      if (load_id)             id_vld_q <= 1'b1;
      else if (bus.clr_ID_vld) id_vld_q <= 1'b0;
    end
  end

  assign bus.ID     = id_q;
  assign bus.ID_vld = id_vld_q;

endmodule

// File: tb/tb_barcode_id_rcv.sv
// ----------------------------------------------------------------------------
// tb_barcode_id_rcv
//   Self-checking bench for barcode_id_rcv. Frame drivers push the expected
//   ID and the expected update cycle; a monitor pops and compares whenever
//   the DUT publishes a new ID.
// ----------------------------------------------------------------------------
module tb_barcode_id_rcv;

  localparam int SYNC_STAGES = 2;
`ifdef BC_GLITCH_FILT_EN
  localparam int FILT_LAT = 2;
`else
  localparam int FILT_LAT = 0;
`endif
  // Last data fall driven at cycle p: synced after SYNC_STAGES, fall seen
  // one cycle later, sample T+1 = u cycles on, DONE one more cycle.
  localparam int LAT_EXTRA = SYNC_STAGES + 2 + FILT_LAT;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  barcode_id_rcv_if bus ();

  barcode_id_rcv #(.PERIOD_W(12), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] id;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t ev;
  logic [7:0] prev_id;
  logic       prev_vld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: a new ID is published when ID_vld rises or ID changes
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_id  = 8'h00;
      prev_vld = 1'b0;
    end else begin
      if ((bus.ID_vld && !prev_vld) || (bus.ID != prev_id)) begin
        if (exp_q.size() == 0) begin
          check("spurious_update", 32'(exp_q.size()), 32'd1);
        end else begin
          ev = exp_q.pop_front();
          check("frame_id", 32'(bus.ID), 32'(ev.id));
          check("frame_latency", 32'(cyc), 32'(ev.cyc));
        end
      end
      prev_id  = bus.ID;
      prev_vld = bus.ID_vld;
    end
  end

  task automatic idle(input int n);
    bus.BC = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_start(input int u);
    bus.BC = 1'b0;
    repeat (u) @(negedge clk);
    bus.BC = 1'b1;
    repeat (u) @(negedge clk);
  endtask

  // One bit cell of 2u cycles: 0 = low 1.5u, 1 = low 0.5u. With clr_same,
  // clr_ID_vld is high across the edge that would set ID_vld.
  task automatic send_bit(input bit b, input int u, input bit clr_same);
    int low;
    low = b ? u / 2 : u + u / 2;
    for (int i = 0; i < 2 * u; i++) begin
      bus.BC = (i < low) ? 1'b0 : 1'b1;
      if (clr_same) bus.clr_ID_vld = (i == u + LAT_EXTRA - 1);
      @(negedge clk);
    end
    bus.clr_ID_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v, input int u, input bit ok, input bit clr_same);
    send_start(u);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && ok) exp_q.push_back('{v, cyc + u + LAT_EXTRA});
      send_bit(v[i], u, clr_same && (i == 0));
    end
    idle(20);
  endtask

  task automatic pulse_clr();
    bus.clr_ID_vld = 1'b1;
    @(negedge clk);
    bus.clr_ID_vld = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.BC         = 1'b1;
    bus.clr_ID_vld = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(100);
    check("reset_id", 32'(bus.ID), 32'h00);
    check("reset_vld", 32'(bus.ID_vld), 32'd0);

    // Clear with nothing pending has no effect
    pulse_clr();
    check("clr_idle_vld", 32'(bus.ID_vld), 32'd0);

    // Long period frame, then a discarded frame with upper bits set
    send_frame(8'h05, 1000, 1'b1, 1'b0);
    send_frame(8'hC7, 100, 1'b0, 1'b0);
    check("discard_id", 32'(bus.ID), 32'h05);
    check("discard_vld", 32'(bus.ID_vld), 32'd1);

    // New frame without acknowledge overwrites ID, ID_vld stays set
    send_frame(8'h06, 100, 1'b1, 1'b0);
    check("overwrite_id", 32'(bus.ID), 32'h06);
    check("overwrite_vld", 32'(bus.ID_vld), 32'd1);

    pulse_clr();
    check("clr_vld", 32'(bus.ID_vld), 32'd0);
    check("clr_id_hold", 32'(bus.ID), 32'h06);

    // Acknowledge in the same cycle as a valid DONE: set wins
    send_frame(8'h12, 100, 1'b1, 1'b1);
    check("set_priority_vld", 32'(bus.ID_vld), 32'd1);

    // Abort after 3 bits, line held high until the timeout
    pulse_clr();
    send_start(100);
    send_bit(1'b0, 100, 1'b0);
    send_bit(1'b1, 100, 1'b0);
    send_bit(1'b0, 100, 1'b0);
    idle(4300);
    check("abort_vld", 32'(bus.ID_vld), 32'd0);
    check("abort_id", 32'(bus.ID), 32'h12);
    send_frame(8'h2A, 100, 1'b1, 1'b0);

    // Reset in the middle of bit 4
    send_start(100);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 100, 1'b0);
    bus.BC = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_id", 32'(bus.ID), 32'h00);
    check("midframe_rst_vld", 32'(bus.ID_vld), 32'd0);
    @(negedge clk);
    bus.BC = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(50);

`ifdef BC_GLITCH_FILT_EN
    // A 2-cycle low pulse must not start a frame
    bus.BC = 1'b0;
    repeat (2) @(negedge clk);
    idle(50);
`endif

    send_frame(8'h11, 100, 1'b1, 1'b0);
    check("post_rst_vld", 32'(bus.ID_vld), 32'd1);

    idle(50);
    check("all_frames_seen", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/barcode_id_rcv.md
Name: barcode_id_rcv

Overview:
- Receiver that decodes the station-ID barcode stripe under the follower into an 8-bit station ID.
- Produces the ID / ID_vld / clr_ID_vld handshake consumed by the command/control block, so it sits at the opposite end of that interface.
- Input is the single-bit optical barcode line (BC). Frame self-clocking: one start bit, then 8 data bits, MSB first.

Parameters:
PERIOD_W, 22, width of the period/timeout counter; counter value all-ones = timeout.
SYNC_STAGES, 2, number of metastability flops on BC before edge detection (minimum 2).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
BC  input  1  raw barcode line, idle high, asynchronous to clk
clr_ID_vld  input  1  consumer acknowledge; clears ID_vld
ID  output  8  last accepted station ID; stable while ID_vld=1
ID_vld  output  1  new valid ID available; held until cleared

Behaviour:
- Reset is asynchronous and active-low (rst_n). Clock is clk (single clock domain).
- Reset values: ID=8'h00, ID_vld=0, shift reg=0, bit count=0, counter=0, state=IDLE, sync flops=1 (line idle).
- BC passes through SYNC_STAGES flops plus one history flop. Definitions on synced signals:
  - fall = prev high and current low.
  - rise = prev low and current high.
- FSM states:
  - IDLE: wait for fall; on fall, clear counter and go to START.
  - START: counter increments each cycle while synced BC low. On rise, latch counter into period reg (T) and go to WAIT_FALL. If the counter reaches all-ones, go to IDLE (timeout).
  - WAIT_FALL: counter counts from 0. On fall, clear counter and go to BIT_DLY. On counter all-ones, go to IDLE.
  - BIT_DLY: counter increments. When counter == T:
    - sample synced BC (1 if high), shift into LSB of shift reg, increment bit count.
    - If bit count was 7, go to DONE; else go to WAIT_FALL.
  - DONE: one cycle, then IDLE.
    - If shift[7:6]==2'b00: load ID <= shift, set ID_vld.
    - Otherwise discard the frame; ID and ID_vld are unchanged.
- Latency:
  - Data-bit sample occurs T+1 cycles after the synced fall.
  - ID/ID_vld update 1 cycle after the 8th sample (DONE).
  - Plus SYNC_STAGES+1 cycles of input latency.
- T == 0 (start low for less than 1 synced cycle) is treated as glitch: return to IDLE.
- ID_vld is set/clear; set has priority when DONE-valid and clr_ID_vld occur in the same cycle.
- New valid frame while ID_vld=1: ID is overwritten and ID_vld stays 1.
- clr_ID_vld while ID_vld=0: no effect.
- ID never changes except in a valid DONE cycle; the shift reg is internal only.
- Counter saturates at all-ones and never wraps.
- rst_n asserted mid-frame: immediate return to reset values. After release, a partial frame still on the line is ignored until the next idle-high then fall.

Optional Feature:
BC_GLITCH_FILT_EN
- Defined:
  - Synced BC passes through a 3-sample majority/consistency filter. Filtered output changes only after 3 consecutive equal samples.
  - Edges are detected on the filtered signal, which adds 2 cycles of input latency.
  - Pulses of 1-2 cycles are rejected.
- Undefined: edges are detected directly on the synced BC, with no added latency.

Test Plan:
- Reset release, BC idle high for 100 cycles -> ID=0x00, ID_vld=0, FSM in IDLE.
- T=1000 clk, frame 0x05 (bits 0 = low 1500, 1 = low 500, each bit cell 2000) -> ID=0x05, ID_vld=1 one cycle after 8th sample; second frame 0x06 without clr -> ID=0x06, ID_vld stays 1.
- Frame 0xC7 (upper bits 11) after ID=0x05 -> ID stays 0x05, ID_vld unchanged.
- ID_vld=1, pulse clr_ID_vld 1 cycle -> ID_vld=0 next cycle, ID holds. Same-cycle clr and valid DONE -> ID_vld=1.
- Frame aborted after 3 bits (BC held high): with PERIOD_W=12, at counter 4095 -> IDLE; ID_vld=0; the following full frame 0x2A is accepted correctly.
- rst_n low mid-bit 4 -> outputs reset immediately. With BC_GLITCH_FILT_EN, 2-cycle low pulse during IDLE -> no START entry; a 0x11 frame then decodes correctly.
